// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// parity mode codes and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on the last cycle of a bit.
// pre_tick flags the cycle before tick so registered outputs can line up with it.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a synchronous FIFO (1-cycle read latency)
// and sends start / 8 data LSB-first / optional parity / stop, all outputs registered.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done,
  output logic [2:0] dbg_state
);

  uart_state_e state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        par_bit;
  logic        tick;
  logic        pre_tick;
  logic        clear;

  // Handshake: fifo_rd_en is a one-cycle read strobe issued only while the FIFO
  // reports non-empty; the FIFO presents the word on fifo_data one cycle later.

  // The bit timer only runs in the timed states; it self-wraps at each bit boundary.
  assign clear     = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);
  assign dbg_state = state;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      par_bit    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      byte_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state      <= ST_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shreg   <= fifo_data;
          par_bit <= ^fifo_data;
          state   <= ST_START;
          tx      <= 1'b0;
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(FRAME_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit ^ (PARITY == PAR_ODD);
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          // byte_done is registered, so it is armed one cycle before the final stop cycle
          if (pre_tick) byte_done <= 1'b1;
          if (tick) begin
            if (!fifo_empty) begin
              state      <= ST_FETCH;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one FIFO-backed instance plus three
// directly-fed instances covering even/odd parity and the minimum bit period.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main instance (N=4, no parity) with FIFO model ----------
  logic       m_empty, m_rd_en, m_tx, m_busy, m_done;
  logic [7:0] m_data;
  logic [2:0] m_state;
  logic       f_wr = 1'b0;
  logic [7:0] f_wd = 8'h00;
  logic [7:0] f_mem [8];
  logic [2:0] f_wp = 3'd0;
  logic [2:0] f_rp = 3'd0;
  int         f_cnt = 0;
  int         rd_cnt = 0;
  int         rd_on_empty = 0;

  assign m_empty = (f_cnt == 0);

  always @(posedge clk) begin
    if (f_wr && f_cnt < 8) begin
      f_mem[f_wp] <= f_wd;
      f_wp        <= f_wp + 3'd1;
    end
    if (m_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (f_cnt != 0) begin
        m_data <= f_mem[f_rp];
        f_rp   <= f_rp + 3'd1;
      end else begin
        rd_on_empty <= rd_on_empty + 1;
      end
    end
    f_cnt <= f_cnt + ((f_wr && f_cnt < 8) ? 1 : 0) - ((m_rd_en && f_cnt != 0) ? 1 : 0);
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u_main (
    .clk(clk), .rst(rst), .fifo_empty(m_empty), .fifo_data(m_data),
    .fifo_rd_en(m_rd_en), .tx(m_tx), .busy(m_busy), .byte_done(m_done), .dbg_state(m_state)
  );

  // ---------------- directly-fed instances ----------------------------------
  logic       aux_empty [1:3];
  logic [7:0] aux_data  [1:3];
  logic       a1_rd, a1_tx, a1_busy, a1_done;
  logic       a2_rd, a2_tx, a2_busy, a2_done;
  logic       a3_rd, a3_tx, a3_busy, a3_done;
  logic [2:0] a1_st, a2_st, a3_st;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1)) u_even (
    .clk(clk), .rst(rst), .fifo_empty(aux_empty[1]), .fifo_data(aux_data[1]),
    .fifo_rd_en(a1_rd), .tx(a1_tx), .busy(a1_busy), .byte_done(a1_done), .dbg_state(a1_st)
  );
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .fifo_empty(aux_empty[2]), .fifo_data(aux_data[2]),
    .fifo_rd_en(a2_rd), .tx(a2_tx), .busy(a2_busy), .byte_done(a2_done), .dbg_state(a2_st)
  );
  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY(0)) u_n2 (
    .clk(clk), .rst(rst), .fifo_empty(aux_empty[3]), .fifo_data(aux_data[3]),
    .fifo_rd_en(a3_rd), .tx(a3_tx), .busy(a3_busy), .byte_done(a3_done), .dbg_state(a3_st)
  );

  function automatic logic get_tx(input int s);
    case (s)
      1: return a1_tx;
      2: return a2_tx;
      3: return a3_tx;
      default: return m_tx;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      1: return a1_busy;
      2: return a2_busy;
      3: return a3_busy;
      default: return m_busy;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      1: return a1_done;
      2: return a2_done;
      3: return a3_done;
      default: return m_done;
    endcase
  endfunction

  function automatic logic get_rd(input int s);
    case (s)
      1: return a1_rd;
      2: return a2_rd;
      3: return a3_rd;
      default: return m_rd_en;
    endcase
  endfunction

  // ---------------- checking --------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------------------------------------
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    f_wr = 1'b1;
    f_wd = b;
    @(negedge clk);
    f_wr = 1'b0;
  endtask

  // Offer one byte to an aux instance and withdraw it once the read strobe is seen.
  task automatic feed_aux(input int s, input logic [7:0] b, input string tag);
    bit seen = 0;
    @(negedge clk);
    aux_data[s]  = b;
    aux_empty[s] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (get_rd(s)) seen = 1;
    end
    aux_empty[s] = 1'b1;
    check({tag, "_rd_seen"}, 64'(seen), 64'd1);
  endtask

  // Leaves the caller at the negedge of the first start-bit cycle.
  task automatic wait_start(input int s, input string tag);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (get_tx(s) == 1'b0) found = 1;
    end
    if (!found) check({tag, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  // Samples tx once per cycle across a whole frame, starting at the current negedge.
  task automatic collect(input int s, input logic [7:0] b, input int par, input int n,
                         input string tag);
    logic [10:0] fb;
    logic [63:0] exp_v, obs_v;
    int nb, k, dn;
    logic bz;
    fb    = '0;
    fb[0] = 1'b0;
    fb[8:1] = b;
    if (par != 0) begin
      fb[9]  = (^b) ^ (par == 2);
      fb[10] = 1'b1;
      nb     = 11;
    end else begin
      fb[9] = 1'b1;
      nb    = 10;
    end
    exp_v = '0;
    obs_v = '0;
    k = 0;
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < n; c++) begin
        exp_v[k] = fb[i];
        k++;
      end
    dn = 0;
    bz = 1'b1;
    for (int j = 0; j < nb * n; j++) begin
      if (j > 0) @(negedge clk);
      obs_v[j] = get_tx(s);
      if (!get_busy(s)) bz = 1'b0;
      if (get_done(s)) dn++;
    end
    check({tag, "_frame"}, obs_v, exp_v);
    check({tag, "_busy"}, 64'(bz), 64'd1);
    check({tag, "_done_cnt"}, 64'(dn), 64'd1);
  endtask

  // Counts idle-high cycles until the next start bit; ends at the start-bit negedge.
  task automatic gap(input int s, input string tag);
    int hi = 0;
    logic bz = 1'b1;
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (get_tx(s) == 1'b0) found = 1;
      else begin
        hi++;
        if (!get_busy(s)) bz = 1'b0;
      end
    end
    check({tag, "_gap"}, 64'(hi), 64'd2);
    check({tag, "_gap_busy"}, 64'(bz), 64'd1);
  endtask

  // ---------------- stimulus ---------------------------------------------------
  logic [7:0] burst [9] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h7E};

  initial begin
    int rd_snap;
    logic tx_all_hi;
    for (int s = 1; s <= 3; s++) begin
      aux_empty[s] = 1'b1;
      aux_data[s]  = 8'h00;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(m_tx), 64'd1);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_rd_en", 64'(m_rd_en), 64'd0);
    check("rst_done", 64'(m_done), 64'd0);
    check("rst_state", 64'(m_state), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_read", 64'(rd_cnt), 64'd0);
    check("idle_tx", 64'(m_tx), 64'd1);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 each for 4 cycles
    push(8'hA5);
    wait_start(0, "a5");
    collect(0, 8'hA5, 0, 4, "a5");
    check("a5_rd_once", 64'(rd_cnt), 64'd1);
    repeat (3) @(negedge clk);
    check("a5_idle_busy", 64'(m_busy), 64'd0);

    // parity: 0xA5 has four ones -> even bit 0, odd bit 1
    feed_aux(1, 8'hA5, "even");
    wait_start(1, "even");
    collect(1, 8'hA5, 1, 4, "even");
    feed_aux(2, 8'hA5, "odd");
    wait_start(2, "odd");
    collect(2, 8'hA5, 2, 4, "odd");
    feed_aux(2, 8'h01, "odd1");
    wait_start(2, "odd1");
    collect(2, 8'h01, 2, 4, "odd1");

    // minimum bit period
    feed_aux(3, 8'h3C, "n2");
    wait_start(3, "n2");
    collect(3, 8'h3C, 0, 2, "n2");

    // back-to-back 0x00 then 0xFF
    push(8'h00);
    push(8'hFF);
    wait_start(0, "b2b0");
    collect(0, 8'h00, 0, 4, "b2b0");
    gap(0, "b2b");
    collect(0, 8'hFF, 0, 4, "b2b1");
    repeat (3) @(negedge clk);
    check("b2b_end_busy", 64'(m_busy), 64'd0);
    check("b2b_end_state", 64'(m_state), 64'd0);

    // burst: one byte in flight, then fill the FIFO to 8 entries
    push(burst[0]);
    fork
      begin
        repeat (2) @(negedge clk);
        for (int i = 1; i < 9; i++) push(burst[i]);
      end
      begin
        wait_start(0, "burst");
        collect(0, burst[0], 0, 4, "burst0");
        for (int i = 1; i < 9; i++) begin
          gap(0, "burst");
          collect(0, burst[i], 0, 4, $sformatf("burst%0d", i));
        end
      end
    join
    repeat (3) @(negedge clk);
    check("burst_fifo_drained", 64'(f_cnt), 64'd0);
    check("rd_total", 64'(rd_cnt), 64'd12);

    // reset during DATA bit 3 of 0xA5 (bit 3 is 0)
    push(8'hA5);
    wait_start(0, "rstmid");
    repeat (17) @(negedge clk);
    check("rstmid_pre_tx", 64'(m_tx), 64'd0);
    rst = 1'b1;
    #1;
    check("rstmid_tx", 64'(m_tx), 64'd1);
    check("rstmid_busy", 64'(m_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_snap = rd_cnt;
    tx_all_hi = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_tx) tx_all_hi = 1'b0;
    end
    check("rstmid_tx_hold", 64'(tx_all_hi), 64'd1);
    check("rstmid_no_read", 64'(rd_cnt - rd_snap), 64'd0);
    check("rd_on_empty", 64'(rd_on_empty), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case a wait loop is bypassed.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter PARITY, default 0, selecting parity: 0 none, 1 even, 2 odd.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the upstream 8x8 synchronous FIFO.
REQ-006 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after a read is accepted.
REQ-007 SHALL have port fifo_rd_en  output  1  read request to the FIFO.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever a byte is being fetched or sent.
REQ-010 SHALL have port byte_done  output  1  single-cycle pulse when a frame's stop bit completes.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 IDLE SHALL move to FETCH on the first edge where fifo_empty=0; it SHALL stay in IDLE otherwise.
REQ-013 FETCH SHALL last exactly 1 cycle with fifo_rd_en=1; fifo_rd_en SHALL be 0 in every other state.
REQ-014 LOAD SHALL last exactly 1 cycle and capture fifo_data into an 8-bit shift register and parity accumulator.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles, tracked by a 3-bit bit index that wraps 7->0 on exit.
REQ-017 PARITY SHALL be entered only when PARITY!=0 and SHALL drive the XOR of the 8 bits (even) or its inverse (odd) for CLKS_PER_BIT cycles; with PARITY=0, DATA SHALL go straight to STOP.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; byte_done SHALL be 1 only in the last cycle of STOP.
REQ-019 Leaving STOP, the FSM SHALL go to FETCH if fifo_empty=0, else to IDLE, so back-to-back frames have exactly 2 idle-high cycles between stop bit and next start bit.
REQ-020 tx SHALL be 1 in IDLE, FETCH and LOAD.
REQ-021 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, clear on every state or bit change, and never overflow.
REQ-023 tx, fifo_rd_en, busy and byte_done SHALL be driven from registers (glitch-free).
REQ-024 fifo_empty SHALL be ignored in all states except IDLE and the last cycle of STOP.

Reset
REQ-025 While rst=1: state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, counters and shift register zero.
REQ-026 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously); the partial byte SHALL be discarded and not resent.
REQ-027 After rst deasserts, the first FETCH SHALL occur no earlier than the first rising edge with fifo_empty=0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding, the PARITY codes (NONE=0, EVEN=1, ODD=2) and the frame bit count (8).
REQ-029 The baud counter SHALL be a sub-module uart_baud_cnt with inputs clk, rst, clear and output tick (last cycle of a bit).
REQ-030 The block SHALL connect directly to the FIFO with no glue logic: fifo_rd_en to its read enable, fifo_data to its data output, fifo_empty to its empty flag.

Verification
REQ-031 CLKS_PER_BIT=4, PARITY=0, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total); byte_done once; fifo_rd_en high for exactly 1 cycle.
REQ-032 CLKS_PER_BIT=4, PARITY=1, 0xA5 -> parity bit 0; PARITY=2 -> parity bit 1; frame is 44 cycles.
REQ-033 Preload 0x00 and 0xFF back-to-back -> exactly 2 high cycles between the first stop bit and the second start bit; busy stays 1 throughout; afterwards IDLE with busy=0.
REQ-034 Fill the FIFO to 8 entries while sending -> 8 frames in write order, no byte lost or duplicated, fifo_rd_en never asserted while fifo_empty=1.
REQ-035 Assert rst during DATA bit 3 -> tx=1 in the same cycle, busy=0; after release with the FIFO empty -> tx stays 1 and no fifo_rd_en.
REQ-036 CLKS_PER_BIT=2 (minimum) with 0x3C -> correct 20-cycle frame, proving the counter boundary.
